wave_gen_pwm: RTL and testbench

Parametrised multi-function waveform generator with a PWM 1-bit output, successor to the fixed 8-bit lab generator. A phase counter, advanced by a programmable power-of-two prescaler, is shaped into sawtooth, triangle, square, DC or pseudo-random samples. Each sample is amplitude-scaled, registered and converted to a glitch-free PWM bitstream for the board DAC/RC filter. It sits directly under the lab top, driven by switch inputs.

---
 rtl/wave_gen_pwm_if.sv | 26 ++
 rtl/wave_gen_pwm.sv | 108 ++++++++++
 tb/tb_wave_gen_pwm.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_gen_pwm_if.sv
// Control and sample bus of the waveform generator: switch-driven controls in,
// shaped sample, advance strobe and PWM bit out.
interface wave_gen_pwm_if #(
  parameter int WIDTH  = 8,
  parameter int FREQ_W = 3
);
  logic              ld_init;
  logic [WIDTH-1:0]  init_val;
  logic [2:0]        func;
  logic [FREQ_W-1:0] freq_sel;
  logic [1:0]        amp_sel;
  logic              phase;
  logic [WIDTH-1:0]  sample;
  logic              sample_tick;
  logic              out;

  modport master (
    output ld_init, init_val, func, freq_sel, amp_sel, phase,
    input  sample, sample_tick, out
  );

  modport slave (
    input  ld_init, init_val, func, freq_sel, amp_sel, phase,
    output sample, sample_tick, out
  );
endinterface

// File: rtl/wave_gen_pwm.sv
// Prescaled phase counter shaped into saw/triangle/square/DC/noise samples,
// attenuated, registered and turned into a glitch-free PWM bitstream.
module wave_gen_pwm #(
  parameter int              WIDTH     = 8,
  parameter int              FREQ_W    = 3,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input logic           clk,
  input logic           rst,
  wave_gen_pwm_if.slave bus
);
  localparam int PRE_W = (1 << FREQ_W) - 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  typedef enum logic [2:0] {
    FN_SAW_UP = 3'b000,
    FN_SAW_DN = 3'b001,
    FN_TRI    = 3'b010,
    FN_SQUARE = 3'b011,
    FN_DC     = 3'b100,
    FN_NOISE  = 3'b101
  } func_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] pwm_q, pwm_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             tick_q, tick_d;
  logic             out_q, out_d;

  logic [PRE_W-1:0] tick_mask;
  logic             tick;
  logic [WIDTH-1:0] p, p_dbl, raw, lfsr_step;

  // Only the low freq_sel prescaler bits take part in the advance decode.
  assign tick_mask = ~({PRE_W{1'b1}} << bus.freq_sel);
  assign tick      = &(pre_q | ~tick_mask);

  assign p         = {cnt_q[WIDTH-1] ^ bus.phase, cnt_q[WIDTH-2:0]};
  assign p_dbl     = {p[WIDTH-2:0], 1'b0};
  assign lfsr_step = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    raw = '0;
    case (func_e'(bus.func))
      FN_SAW_UP: raw = p;
      FN_SAW_DN: raw = ~p;
      FN_TRI:    raw = p[WIDTH-1] ? ~p_dbl : p_dbl;
      FN_SQUARE: raw = p[WIDTH-1] ? '0 : '1;
      FN_DC:     raw = bus.init_val;
      FN_NOISE:  raw = lfsr_q;
      default:   raw = '0;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    pre_d    = pre_q + PRE_ONE;
    lfsr_d   = lfsr_q;
    tick_d   = 1'b0;
    if (bus.ld_init) begin
      cnt_d  = bus.init_val;
      pre_d  = '0;
      // An all-zero Galois register would lock up, so a zero seed becomes 1.
      lfsr_d = (bus.init_val == '0) ? ONE : bus.init_val;
    end else if (tick) begin
      cnt_d  = cnt_q + ONE;
      lfsr_d = lfsr_step;
      tick_d = 1'b1;
    end
    sample_d = raw >> bus.amp_sel;
    pwm_d    = pwm_q + ONE;
    // Duty only reloads on the last count of a period so no pulse is ever cut short.
    duty_d   = (pwm_q == '1) ? sample_q : duty_q;
    out_d    = (pwm_q < duty_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so all of them update from the same pre-edge values.
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      lfsr_q   <= ONE;
      pwm_q    <= '0;
      duty_q   <= '0;
      sample_q <= '0;
      tick_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      pwm_q    <= pwm_d;
      duty_q   <= duty_d;
      sample_q <= sample_d;
      tick_q   <= tick_d;
      out_q    <= out_d;
    end
  end

  assign bus.sample      = sample_q;
  assign bus.sample_tick = tick_q;
  assign bus.out         = out_q;
endmodule

// File: tb/tb_wave_gen_pwm.sv
// Self-checking bench for wave_gen_pwm: directed corner sequences, a vector
// table of shaping cases and randomized traffic against an arithmetic model.
module tb_wave_gen_pwm;
  localparam int W  = 8;
  localparam int FW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_gen_pwm_if #(.WIDTH(W), .FREQ_W(FW)) bus ();
  wave_gen_pwm #(.WIDTH(W), .FREQ_W(FW), .LFSR_TAPS(8'hB8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, the value each register holds after the most recent edge.
  int m_cnt, m_pre, m_lfsr, m_sample, m_tick, m_pwm, m_duty, m_out;

  typedef struct {
    string      name;
    logic [2:0] func;
    logic [1:0] amp;
    logic       ph;
    logic [7:0] init;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int x);
    return (x % 2 == 1) ? ((x / 2) ^ 'hB8) : (x / 2);
  endfunction

  function automatic int shape(input int f, input int cnt, input int ph,
                               input int init, input int lfsr, input int amp);
    int p, r;
    p = (cnt + (ph != 0 ? 128 : 0)) % 256;
    case (f)
      0:       r = p;
      1:       r = 255 - p;
      2:       r = (p < 128) ? 2 * p : 511 - 2 * p;
      3:       r = (p < 128) ? 255 : 0;
      4:       r = init;
      5:       r = lfsr;
      default: r = 0;
    endcase
    return r / (1 << amp);
  endfunction

  task automatic model_step();
    int n_cnt, n_pre, n_lfsr, n_sample, n_tick, n_pwm, n_duty, n_out, per;
    n_cnt = m_cnt; n_pre = m_pre; n_lfsr = m_lfsr; n_tick = 0;
    if (rst) begin
      n_cnt = 0; n_pre = 0; n_lfsr = 1; n_sample = 0;
      n_pwm = 0; n_duty = 0; n_out = 0;
    end else begin
      n_sample = shape(int'(bus.func), m_cnt, int'(bus.phase), int'(bus.init_val),
                       m_lfsr, int'(bus.amp_sel));
      n_out  = (m_pwm < m_duty) ? 1 : 0;
      n_duty = (m_pwm == 255) ? m_sample : m_duty;
      n_pwm  = (m_pwm + 1) % 256;
      if (bus.ld_init) begin
        n_cnt  = int'(bus.init_val);
        n_pre  = 0;
        n_lfsr = (bus.init_val == 0) ? 1 : int'(bus.init_val);
      end else begin
        per   = 1 << int'(bus.freq_sel);
        n_pre = (m_pre + 1) % 128;
        if (m_pre % per == per - 1) begin
          n_cnt  = (m_cnt + 1) % 256;
          n_lfsr = lfsr_next(m_lfsr);
          n_tick = 1;
        end
      end
    end
    m_cnt = n_cnt; m_pre = n_pre; m_lfsr = n_lfsr; m_sample = n_sample;
    m_tick = n_tick; m_pwm = n_pwm; m_duty = n_duty; m_out = n_out;
  endtask

  task automatic step(input bit cmp);
    @(posedge clk);
    model_step();
    #1;
    if (cmp) begin
      check("sample", bus.sample, m_sample);
      check("sample_tick", bus.sample_tick, m_tick);
      check("out", bus.out, m_out);
    end
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      if (bus.out === 1'b1) hi++;
    end
  endtask

  task automatic align_pwm();
    int guard;
    guard = 0;
    while (m_pwm != 0 && guard < 300) begin
      step(1'b1);
      guard++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[14];
    int   hi, waited, per, s1, zeros, distinct;
    int   vals[256];
    bit   seen[256];

    vecs[0]  = '{"saw_up",        3'b000, 2'd0, 1'b0, 8'h10, 8'h10};
    vecs[1]  = '{"saw_up_ph",     3'b000, 2'd0, 1'b1, 8'h10, 8'h90};
    vecs[2]  = '{"saw_dn",        3'b001, 2'd0, 1'b0, 8'h10, 8'hEF};
    vecs[3]  = '{"tri_40",        3'b010, 2'd0, 1'b0, 8'h40, 8'h80};
    vecs[4]  = '{"tri_C0",        3'b010, 2'd0, 1'b0, 8'hC0, 8'h7F};
    vecs[5]  = '{"square_amp2",   3'b011, 2'd2, 1'b0, 8'h10, 8'h3F};
    vecs[6]  = '{"square_ph",     3'b011, 2'd2, 1'b1, 8'h10, 8'h00};
    vecs[7]  = '{"dc_amp1",       3'b100, 2'd1, 1'b0, 8'h40, 8'h20};
    vecs[8]  = '{"noise_seed",    3'b101, 2'd0, 1'b0, 8'h5A, 8'h5A};
    vecs[9]  = '{"noise_zero",    3'b101, 2'd0, 1'b0, 8'h00, 8'h01};
    vecs[10] = '{"func_110",      3'b110, 2'd0, 1'b0, 8'h33, 8'h00};
    vecs[11] = '{"func_111",      3'b111, 2'd0, 1'b0, 8'hA5, 8'h00};
    vecs[12] = '{"tri_7F_amp3",   3'b010, 2'd3, 1'b0, 8'h7F, 8'h1F};
    vecs[13] = '{"saw_FF_amp3ph", 3'b000, 2'd3, 1'b1, 8'hFF, 8'h0F};

    rst = 1'b1;
    bus.ld_init = 1'b0; bus.init_val = '0; bus.func = 3'b000;
    bus.freq_sel = '0; bus.amp_sel = 2'd0; bus.phase = 1'b0;

    // Reset hold, then a unit-rate ramp.
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      check("rst_sample", bus.sample, 0);
      check("rst_out", bus.out, 0);
      check("rst_tick", bus.sample_tick, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      check("ramp_sample", bus.sample, i);
      check("ramp_tick", bus.sample_tick, 1);
    end

    // Prescaler by 8: tick spacing and one sample step per tick.
    bus.freq_sel = 3'd3;
    step(1'b0);
    waited = 0;
    while (bus.sample_tick !== 1'b1 && waited < 20) begin
      step(1'b0);
      waited++;
    end
    check("tick_found", (waited < 20) ? 1 : 0, 1);
    for (int r = 0; r < 2; r++) begin
      s1 = int'(bus.sample);
      per = 0;
      do begin
        step(1'b0);
        per++;
      end while (bus.sample_tick !== 1'b1 && per < 20);
      check("tick_period", per, 8);
      check("tick_step", bus.sample, (s1 + 1) % 256);
    end

    // Counter wrap through a load.
    bus.freq_sel = 3'd0; bus.init_val = 8'hFE; bus.ld_init = 1'b1;
    step(1'b0);
    check("ld_tick_low", bus.sample_tick, 0);
    bus.ld_init = 1'b0;
    step(1'b0); check("wrap_FE", bus.sample, 8'hFE);
    step(1'b0); check("wrap_FF", bus.sample, 8'hFF);
    step(1'b0); check("wrap_00", bus.sample, 8'h00);

    // Shaping table, slow prescaler so the loaded phase holds still.
    bus.freq_sel = 3'd7;
    foreach (vecs[k]) begin
      bus.func = vecs[k].func; bus.amp_sel = vecs[k].amp; bus.phase = vecs[k].ph;
      bus.init_val = vecs[k].init; bus.ld_init = 1'b1;
      step(1'b0);
      bus.ld_init = 1'b0;
      step(1'b0);
      check(vecs[k].name, bus.sample, int'(vecs[k].exp));
    end

    // Reset beats a simultaneous load.
    bus.func = 3'b000; bus.amp_sel = 2'd0; bus.phase = 1'b0;
    rst = 1'b1; bus.ld_init = 1'b1; bus.init_val = 8'h55;
    step(1'b0);
    rst = 1'b0; bus.ld_init = 1'b0;
    step(1'b0);
    check("rst_over_ld", bus.sample, 0);

    // PWM duty at DC levels, including a mid-period level change.
    rst = 1'b1; step(1'b0); rst = 1'b0;
    bus.func = 3'b100; bus.init_val = 8'h40; bus.freq_sel = 3'd0;
    for (int i = 0; i < 300; i++) step(1'b1);
    align_pwm();
    count_high(256, hi); check("pwm_40_full", hi, 64);
    count_high(100, hi); check("pwm_40_head", hi, 64);
    bus.init_val = 8'h80;
    count_high(156, hi); check("pwm_hold_tail", hi, 0);
    count_high(256, hi); check("pwm_80_full", hi, 128);
    bus.init_val = 8'hFF;
    count_high(256, hi); check("pwm_ff_pending", hi, 128);
    count_high(256, hi); check("pwm_ff_full", hi, 255);
    bus.init_val = 8'h00;
    count_high(256, hi); check("pwm_00_pending", hi, 255);
    count_high(256, hi); check("pwm_00_full", hi, 0);

    // Noise: zero seed, full-length sequence.
    rst = 1'b1; step(1'b0); rst = 1'b0;
    bus.func = 3'b101; bus.init_val = 8'h00; bus.ld_init = 1'b1;
    step(1'b1);
    bus.ld_init = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step(1'b0);
      vals[i] = int'(bus.sample);
    end
    check("noise_first", vals[0], 8'h01);
    check("noise_second", vals[1], 8'hB8);
    check("noise_third", vals[2], 8'h5C);
    zeros = 0; distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (vals[i] == 0) zeros++;
      if (!seen[vals[i]]) distinct++;
      seen[vals[i]] = 1'b1;
    end
    check("noise_no_zero", zeros, 0);
    check("noise_distinct", distinct, 255);
    check("noise_period", vals[255], vals[0]);

    // Randomized traffic against the model.
    rst = 1'b1; step(1'b1); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      bus.ld_init  = ($urandom_range(0, 49) == 0);
      bus.init_val = 8'($urandom);
      if ($urandom_range(0, 31) == 0) bus.func = 3'($urandom);
      if ($urandom_range(0, 63) == 0) bus.freq_sel = 3'($urandom_range(0, 4));
      bus.amp_sel  = 2'($urandom);
      bus.phase    = 1'($urandom);
      step(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
